// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-strobe-enabled x/y counters with registered
// sync, visible-area and line/frame markers decoded from the next count values.
module vga_sync_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit SYNC_POL  = 1'b0,
   parameter int CW        = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_en,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_cnt
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] ONE    = CW'(1'b1);
   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
   localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_VISIBLE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_BEG = CW'(V_VISIBLE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic [CW-1:0] x_r, y_r;
   logic [CW-1:0] x_nxt_s, y_nxt_s;
   logic          hsync_r, vsync_r, video_on_r, line_start_r, frame_start_r;
   logic          hs_act_s, vs_act_s, vid_s, lstart_s, fstart_s;
   logic [7:0]    frame_cnt_r;

   // Next raster position and the flags that will accompany it.
   always_comb begin
      x_nxt_s  = x_r;
      y_nxt_s  = y_r;
      if (x_r == H_LAST) begin
         x_nxt_s = ZERO;
         if (y_r == V_LAST) begin
            y_nxt_s = ZERO;
         end else begin
            y_nxt_s = y_r + ONE;
         end
      end else begin
         x_nxt_s = x_r + ONE;
         y_nxt_s = y_r;
      end
      hs_act_s = (x_nxt_s >= HS_BEG) && (x_nxt_s <= HS_END);
      vs_act_s = (y_nxt_s >= VS_BEG) && (y_nxt_s <= VS_END);
      vid_s    = (x_nxt_s < H_VIS) && (y_nxt_s < V_VIS);
      lstart_s = (x_nxt_s == ZERO);
      fstart_s = lstart_s && (y_nxt_s == ZERO);
   end

   // Raster state; markers are cleared on any clk without a strobe so they stay one clk wide.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_r           <= H_LAST;
         y_r           <= V_LAST;
         hsync_r       <= ~SYNC_POL;
         vsync_r       <= ~SYNC_POL;
         video_on_r    <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         frame_cnt_r   <= 8'd0;
      end else if (pix_en) begin
         x_r           <= x_nxt_s;
         y_r           <= y_nxt_s;
         hsync_r       <= hs_act_s ? SYNC_POL : ~SYNC_POL;
         vsync_r       <= vs_act_s ? SYNC_POL : ~SYNC_POL;
         video_on_r    <= vid_s;
         line_start_r  <= lstart_s;
         frame_start_r <= fstart_s;
         frame_cnt_r   <= fstart_s ? (frame_cnt_r + 8'd1) : frame_cnt_r;
      end else begin
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end
   end

   assign x           = x_r;
   assign y           = y_r;
   assign hsync       = hsync_r;
   assign vsync       = vsync_r;
   assign video_on    = video_on_r;
   assign line_start  = line_start_r;
   assign frame_start = frame_start_r;
   assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing, a narrow-line / full-height
// variant for vertical timing, and a tiny variant for frame counter wrap.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // default geometry 800x525
   logic       rst_d, en_d;
   logic [9:0] xd, yd;
   logic       hsd, vsd, vod, lsd, fsd;
   logic [7:0] fcd;

   // 8-pixel lines, default vertical timing
   logic       rst_v, en_v;
   logic [9:0] xv, yv;
   logic       hsv, vsv, vov, lsv, fsv;
   logic [7:0] fcv;

   // 8x4 raster
   logic       rst_s, en_s;
   logic [3:0] xs, ys;
   logic       hss, vss, vos, lss, fss;
   logic [7:0] fcs;

   vga_sync_gen u_d (
      .clk(clk), .rst_n(rst_d), .pix_en(en_d), .x(xd), .y(yd), .hsync(hsd), .vsync(vsd),
      .video_on(vod), .line_start(lsd), .frame_start(fsd), .frame_cnt(fcd)
   );

   vga_sync_gen #(.H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)) u_v (
      .clk(clk), .rst_n(rst_v), .pix_en(en_v), .x(xv), .y(yv), .hsync(hsv), .vsync(vsv),
      .video_on(vov), .line_start(lsv), .frame_start(fsv), .frame_cnt(fcv)
   );

   vga_sync_gen #(.H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                  .V_VISIBLE(2), .V_FP(1), .V_SYNC(1), .V_BP(0), .CW(4)) u_s (
      .clk(clk), .rst_n(rst_s), .pix_en(en_s), .x(xs), .y(ys), .hsync(hss), .vsync(vss),
      .video_on(vos), .line_start(lss), .frame_start(fss), .frame_cnt(fcs)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ex, ey;
      rst_d = 1'b0; en_d = 1'b0;
      rst_v = 1'b0; en_v = 1'b0;
      rst_s = 1'b0; en_s = 1'b0;
      step;
      step;

      // reset state
      chk("rst_x", xd, 799);   chk("rst_y", yd, 524);
      chk("rst_hs", hsd, 1);   chk("rst_vs", vsd, 1);
      chk("rst_vo", vod, 0);   chk("rst_ls", lsd, 0);
      chk("rst_fs", fsd, 0);   chk("rst_fc", fcd, 0);

      // first strobe after reset
      rst_d = 1'b1; en_d = 1'b1;
      step;
      chk("c1_x", xd, 0);  chk("c1_y", yd, 0);  chk("c1_vo", vod, 1);
      chk("c1_ls", lsd, 1); chk("c1_fs", fsd, 1); chk("c1_fc", fcd, 1);
      chk("c1_hs", hsd, 1); chk("c1_vs", vsd, 1);

      // three full lines at one pixel per clk
      for (int k = 1; k < 2400; k++) begin
         step;
         ex = k % 800; ey = k / 800;
         chk("d_x", xd, ex);  chk("d_y", yd, ey);
         chk("d_hs", hsd, (ex >= 656 && ex <= 751) ? 0 : 1);
         chk("d_vo", vod, (ex < 640) ? 1 : 0);
         chk("d_ls", lsd, (ex == 0) ? 1 : 0);
         chk("d_fs", fsd, 0);
         chk("d_vs", vsd, 1);
      end

      // 1-in-4 strobe: state holds and markers stay one clk wide
      for (int i = 1; i <= 900; i++) begin
         en_d = 1'b1;
         step;
         en_d = 1'b0;
         ex = (2399 + i) % 800; ey = (2399 + i) / 800;
         chk("s_x", xd, ex); chk("s_y", yd, ey);
         chk("s_ls", lsd, (ex == 0) ? 1 : 0);
         for (int j = 0; j < 3; j++) begin
            step;
            chk("s_hold_x", xd, ex);  chk("s_hold_y", yd, ey);
            chk("s_hold_hs", hsd, (ex >= 656 && ex <= 751) ? 0 : 1);
            chk("s_hold_vo", vod, (ex < 640) ? 1 : 0);
            chk("s_hold_ls", lsd, 0);
            chk("s_hold_fc", fcd, 1);
         end
      end

      // vertical timing over one full frame plus the wrap into the next
      rst_v = 1'b1; en_v = 1'b1;
      step;
      chk("v1_x", xv, 0); chk("v1_y", yv, 0); chk("v1_fs", fsv, 1);
      chk("v1_fc", fcv, 1); chk("v1_vo", vov, 1);
      for (int k = 1; k <= 4200; k++) begin
         step;
         ex = k % 8; ey = (k / 8) % 525;
         chk("v_x", xv, ex); chk("v_y", yv, ey);
         chk("v_vs", vsv, (ey >= 490 && ey <= 491) ? 0 : 1);
         chk("v_hs", hsv, (ex >= 5 && ex <= 6) ? 0 : 1);
         chk("v_vo", vov, (ex < 4 && ey < 480) ? 1 : 0);
         chk("v_fs", fsv, (k == 4200) ? 1 : 0);
         chk("v_fc", fcv, (k == 4200) ? 2 : 1);
      end

      // mid-frame reset at (3,200) with the strobe still high
      for (int k = 1; k <= 1603; k++) step;
      chk("mid_x", xv, 3); chk("mid_y", yv, 200);
      rst_v = 1'b0;
      step;
      chk("mr_x", xv, 7);   chk("mr_y", yv, 524);
      chk("mr_hs", hsv, 1); chk("mr_vs", vsv, 1);
      chk("mr_vo", vov, 0); chk("mr_ls", lsv, 0);
      chk("mr_fs", fsv, 0); chk("mr_fc", fcv, 0);
      en_v = 1'b0;

      // 256 frames of 32 clks: frame_cnt wraps 255 -> 0
      rst_s = 1'b1; en_s = 1'b1;
      step;
      chk("w1_fc", fcs, 1); chk("w1_fs", fss, 1);
      for (int c = 2; c <= 1 + 32 * 255; c++) begin
         step;
         if (c <= 33) begin
            ex = (c - 1) % 8; ey = ((c - 1) / 8) % 4;
            chk("w_x", xs, ex); chk("w_y", ys, ey);
            chk("w_vs", vss, (ey == 3) ? 0 : 1);
            chk("w_vo", vos, (ex < 4 && ey < 2) ? 1 : 0);
         end
         if (c == 1 + 32 * 254) chk("w_fc255", fcs, 255);
         if (c == 32 * 255) begin
            chk("w_pre_fc", fcs, 255); chk("w_pre_fs", fss, 0);
         end
      end
      chk("w_fc0", fcs, 0); chk("w_fs", fss, 1);
      chk("w_x0", xs, 0);   chk("w_y0", ys, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
